// File: rtl/mc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_seq_ctrl
// Description : Multi-cycle sequencing controller for a MIPS-subset CPU.
//               Moves each instruction through IF, ID, EX, MEM and WB. It
//               waits on the data-memory handshake and drives the datapath
//               enables and selects. PC is written exactly once per
//               instruction.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-high reset
//   opcode     in   6  IR[31:26] from the registered IR
//   funct      in   6  IR[5:0] from the registered IR
//   zero       in   1  ALU equality flag (consumed by the npc unit)
//   mem_ready  in   1  data memory completes the access this cycle
//   state      out  3  IF=0, ID=1, EX=2, MEM=3, WB=4
//   ir_we      out  1  IR load
//   pc_we      out  1  PC load from npc
//   npc_op     out  4  next-PC select
//   rf_we      out  1  register file write
//   rf_wsel    out  2  write address: 0=rd, 1=rt, 2=$31
//   rf_wdsel   out  2  write data: 0=ALU, 1=mem, 2=pc+4
//   alu_op     out  3  0=add, 1=sub, 2=or, 3=lui
//   alu_bsel   out  1  0=rt, 1=extended imm
//   ext_op     out  1  0=zero-extend, 1=sign-extend
//   mem_re     out  1  data-memory read request
//   mem_we     out  1  data-memory write request
//   illegal    out  1  pulse: unsupported instruction skipped
// ============================================================================
module mc_seq_ctrl #(
  parameter logic [3:0] NPC_ADD4 = 4'd0,
  parameter logic [3:0] NPC_BRCH = 4'd1,
  parameter logic [3:0] NPC_JAL  = 4'd2,
  parameter logic [3:0] NPC_JR   = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       ir_we,
  output logic       pc_we,
  output logic [3:0] npc_op,
  output logic       rf_we,
  output logic [1:0] rf_wsel,
  output logic [1:0] rf_wdsel,
  output logic [2:0] alu_op,
  output logic       alu_bsel,
  output logic       ext_op,
  output logic       mem_re,
  output logic       mem_we,
  output logic       illegal
);

  // State encoding
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // Opcodes / functs
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_LUI   = 6'b001111;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_JAL   = 6'b000011;
  localparam logic [5:0] C_FN_ADD   = 6'b100000;
  localparam logic [5:0] C_FN_SUB   = 6'b100010;
  localparam logic [5:0] C_FN_JR    = 6'b001000;

  // ALU operation codes
  localparam logic [2:0] C_ALU_ADD = 3'd0;
  localparam logic [2:0] C_ALU_SUB = 3'd1;
  localparam logic [2:0] C_ALU_OR  = 3'd2;
  localparam logic [2:0] C_ALU_LUI = 3'd3;

  // Write address / data selects
  localparam logic [1:0] C_WSEL_RD  = 2'd0;
  localparam logic [1:0] C_WSEL_RT  = 2'd1;
  localparam logic [1:0] C_WSEL_RA  = 2'd2;
  localparam logic [1:0] C_WD_ALU   = 2'd0;
  localparam logic [1:0] C_WD_MEM   = 2'd1;
  localparam logic [1:0] C_WD_PC4   = 2'd2;

  logic [2:0] r_state;
  logic [2:0] w_next_state;

  // The branch decision is taken by the npc unit, so zero is not needed here.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic w_is_rtype;
  logic w_is_add, w_is_sub, w_is_jr;
  logic w_is_ori, w_is_lui, w_is_lw, w_is_sw, w_is_beq, w_is_jal;
  logic w_is_illegal;

  assign w_is_rtype   = (opcode == C_OP_RTYPE);
  assign w_is_add     = w_is_rtype && (funct == C_FN_ADD);
  assign w_is_sub     = w_is_rtype && (funct == C_FN_SUB);
  assign w_is_jr      = w_is_rtype && (funct == C_FN_JR);
  assign w_is_ori     = (opcode == C_OP_ORI);
  assign w_is_lui     = (opcode == C_OP_LUI);
  assign w_is_lw      = (opcode == C_OP_LW);
  assign w_is_sw      = (opcode == C_OP_SW);
  assign w_is_beq     = (opcode == C_OP_BEQ);
  assign w_is_jal     = (opcode == C_OP_JAL);
  assign w_is_illegal = ~(w_is_add | w_is_sub | w_is_jr | w_is_ori | w_is_lui |
                          w_is_lw | w_is_sw | w_is_beq | w_is_jal);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = S_IF;
    case (r_state)
      S_IF: w_next_state = S_ID;
      S_ID: begin
        if (w_is_jr || w_is_illegal) begin
          w_next_state = S_IF;
        end else if (w_is_jal) begin
          w_next_state = S_WB;
        end else begin
          w_next_state = S_EX;
        end
      end
      S_EX: begin
        if (w_is_beq) begin
          w_next_state = S_IF;
        end else if (w_is_lw || w_is_sw) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (!mem_ready) begin
          w_next_state = S_MEM;
        end else if (w_is_lw) begin
          w_next_state = S_WB;
        end else begin
          w_next_state = S_IF;
        end
      end
      S_WB:    w_next_state = S_IF;
      default: w_next_state = S_IF;  // encodings 5-7 recover to IF
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npc_op   = NPC_ADD4;
    rf_we    = 1'b0;
    rf_wsel  = C_WSEL_RD;
    rf_wdsel = C_WD_ALU;
    alu_op   = C_ALU_ADD;
    alu_bsel = 1'b0;
    ext_op   = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    illegal  = 1'b0;

    case (r_state)
      S_IF: ir_we = 1'b1;
      S_ID: begin
        if (w_is_jr) begin
          pc_we  = 1'b1;
          npc_op = NPC_JR;
        end else if (w_is_illegal) begin
          illegal = 1'b1;
          pc_we   = 1'b1;
          npc_op  = NPC_ADD4;
        end
      end
      S_EX: begin
        if (w_is_sub) begin
          alu_op = C_ALU_SUB;
        end else if (w_is_ori) begin
          alu_op   = C_ALU_OR;
          alu_bsel = 1'b1;
        end else if (w_is_lui) begin
          alu_op   = C_ALU_LUI;
          alu_bsel = 1'b1;
        end else if (w_is_lw || w_is_sw) begin
          alu_op   = C_ALU_ADD;
          alu_bsel = 1'b1;
          ext_op   = 1'b1;
        end else if (w_is_beq) begin
          alu_op = C_ALU_SUB;
          pc_we  = 1'b1;
          npc_op = NPC_BRCH;
        end
      end
      S_MEM: begin
        // The request stays asserted until the cycle memory reports ready.
        if (w_is_lw) begin
          mem_re = 1'b1;
        end else begin
          mem_we = 1'b1;
          if (mem_ready) begin
            pc_we  = 1'b1;
            npc_op = NPC_ADD4;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (w_is_jal) begin
          rf_wsel  = C_WSEL_RA;
          rf_wdsel = C_WD_PC4;
          npc_op   = NPC_JAL;
        end else if (w_is_lw) begin
          rf_wsel  = C_WSEL_RT;
          rf_wdsel = C_WD_MEM;
        end else if (w_is_ori || w_is_lui) begin
          rf_wsel  = C_WSEL_RT;
        end
      end
      default: ;
    endcase

    // IF is the reset state, so its ir_we must be masked while reset is held.
    if (reset) begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      npc_op   = 4'd0;
      rf_we    = 1'b0;
      rf_wsel  = 2'd0;
      rf_wdsel = 2'd0;
      alu_op   = 3'd0;
      alu_bsel = 1'b0;
      ext_op   = 1'b0;
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire
